// File: rtl/armv8_mem_pkg.sv
// Shared definitions for the load/store byte-serial memory units.
package armv8_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Selects one byte lane of a 64-bit word by beat index, optionally mirrored
// within the access size so the most significant stored byte comes first.
module byte_lane_mux
  import armv8_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [63:0] data,
  input  logic [1:0]  size,
  input  logic [2:0]  idx,
  output logic [7:0]  lane
);
  logic [7:0] lanes [8];
  logic [3:0] last_idx;
  logic [2:0] sel;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lanes[gi] = data[8*gi +: 8];
  end

  assign last_idx = size_to_bytes(size) - 4'd1;

  always_comb begin
    sel = idx;
    if (BIG_ENDIAN) begin
      sel = last_idx[2:0] - idx;
    end
    lane = lanes[sel];
  end

endmodule

// File: rtl/store_narrow_serializer.sv
// Writes the low 1/2/4/8 bytes of a register value to a byte-wide memory
// port, one byte per accepted beat, then pulses done (or err_misalign).
module store_narrow_serializer
  import armv8_mem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter bit BIG_ENDIAN  = 1'b0,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_misalign
);
  lsu_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [63:0]       data_reg;
  logic [1:0]        size_reg;
  logic [2:0]        idx_reg;
  logic [3:0]        req_mask;
  logic [3:0]        last_idx;
  logic              misaligned;
  logic              accept;
  logic              last_beat;
  logic [7:0]        lane;

  assign req_mask   = size_to_bytes(req_size) - 4'd1;
  assign misaligned = |(req_addr[2:0] & req_mask[2:0]);
  assign accept     = (state_reg == ST_IDLE) && req_valid;
  assign last_idx   = size_to_bytes(size_reg) - 4'd1;
  assign last_beat  = ({1'b0, idx_reg} == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request fields are captured once; later req_* changes cannot disturb a store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= '0;
      data_reg <= '0;
      size_reg <= SZ_B;
      idx_reg  <= '0;
    end else if (accept) begin
      addr_reg <= req_addr;
      data_reg <= req_data;
      size_reg <= req_size;
      idx_reg  <= '0;
    end else if ((state_reg == ST_WRITE) && mem_ready && !last_beat) begin
      idx_reg <= idx_reg + 3'd1;
    end
  end

  byte_lane_mux #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_mux (
    .data(data_reg),
    .size(size_reg),
    .idx (idx_reg),
    .lane(lane)
  );

  always_comb begin
    state_next   = state_reg;
    req_ready    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = 1'b1;
    done         = 1'b0;
    err_misalign = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_next = (CHECK_ALIGN && misaligned) ? ST_ERR : ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg + {{(ADDR_W-3){1'b0}}, idx_reg};
        mem_wdata = lane;
        if (mem_ready && last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        err_misalign = 1'b1;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
